// File: rtl/timer_peripheral.sv
// timer_peripheral
//
// Memory-mapped peripheral window (64 bytes at BASE_ADDR) on the CPU data bus.
// It holds a reload timer that drives the CPU interrupt, an LED register,
// a synchronised switch input register and a 7-segment digit register.
// Loads are combinational so the CPU sees data in the same cycle.
// Stores commit on the rising clock edge.
//
// Optional feature: define PERIPH_SYSTICK_EN to add a free-running 32-bit
// cycle counter, readable at offset 0x24.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset
//   addr      byte address from the CPU (addr[1:0] ignored)
//   wdata     store data
//   MemWrite  store strobe, sampled on the rising edge
//   MemRead   load strobe; rdata is zero when low
//   rdata     combinational load data
//   switch    asynchronous board switches
//   led       LED register
//   digi      digit register: [11:8] anode select, [7:0] segments
//   irqout    interrupt request (TCON interrupt enable AND status)
//
// Register map (byte offsets):
//   0x00 TH, 0x04 TL, 0x08 TCON[2:0], 0x0C LED[7:0], 0x10 SWITCH[7:0] (RO),
//   0x14 DIGI[11:0], 0x24 SYSTICK (RO, only with PERIPH_SYSTICK_EN).
//   0x18-0x20 belong to the UART block and read as zero here.

module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] rdata,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irqout
);

    localparam logic [3:0] IDX_TH      = 4'd0;
    localparam logic [3:0] IDX_TL      = 4'd1;
    localparam logic [3:0] IDX_TCON    = 4'd2;
    localparam logic [3:0] IDX_LED     = 4'd3;
    localparam logic [3:0] IDX_SWITCH  = 4'd4;
    localparam logic [3:0] IDX_DIGI    = 4'd5;
    localparam logic [3:0] IDX_SYSTICK = 4'd9;

    logic        in_window;
    logic [3:0]  word_idx;
    logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
    logic [31:0] th, tl;
    logic [2:0]  tcon;
    logic [7:0]  sw_meta, sw_sync;
    logic        overflow;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    assign in_window = (addr[31:6] == BASE_ADDR[31:6]);
    assign word_idx  = addr[5:2];

    assign wr_th   = MemWrite & in_window & (word_idx == IDX_TH);
    assign wr_tl   = MemWrite & in_window & (word_idx == IDX_TL);
    assign wr_tcon = MemWrite & in_window & (word_idx == IDX_TCON);
    assign wr_led  = MemWrite & in_window & (word_idx == IDX_LED);
    assign wr_digi = MemWrite & in_window & (word_idx == IDX_DIGI);

    // Counter wraps this cycle; reload always uses the TH value held before
    // the edge, so a same-cycle TH store only affects the following reload.
    assign overflow = tcon[0] & (tl == 32'hFFFF_FFFF);

    // Timer and output registers. Bus stores take priority over counting and
    // over the status set, so a clearing TCON store can never be lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th   <= 32'h0;
            tl   <= 32'h0;
            tcon <= 3'b000;
            led  <= 8'h00;
            digi <= 12'h000;
        end else begin
            if (wr_th)
                th <= wdata;

            if (wr_tl)
                tl <= wdata;
            else if (overflow)
                tl <= th;
            else if (tcon[0])
                tl <= tl + 32'd1;

            if (wr_tcon)
                tcon <= wdata[2:0];
            else if (overflow && tcon[1])
                tcon[2] <= 1'b1;

            if (wr_led)
                led <= wdata[7:0];

            if (wr_digi)
                digi <= wdata[11:0];
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= 8'h00;
            sw_sync <= 8'h00;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick;

    // Free-running cycle counter; not writable from the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            systick <= 32'h0;
        else
            systick <= systick + 32'd1;
    end
`endif

    assign irqout = tcon[1] & tcon[2];

    // Combinational read mux; anything unmapped or unqualified reads zero.
    always_comb begin
        rdata = 32'h0;
        if (MemRead && in_window) begin
            case (word_idx)
                IDX_TH:      rdata = th;
                IDX_TL:      rdata = tl;
                IDX_TCON:    rdata = {29'h0, tcon};
                IDX_LED:     rdata = {24'h0, led};
                IDX_SWITCH:  rdata = {24'h0, sw_sync};
                IDX_DIGI:    rdata = {20'h0, digi};
`ifdef PERIPH_SYSTICK_EN
                IDX_SYSTICK: rdata = systick;
`endif
                default:     rdata = 32'h0;
            endcase
        end
    end

endmodule
